// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, ACK/NACK levels and R/W bit encoding.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with SCL edge strobes and START/STOP condition strobes.
// Shared between slave and master; both lines are treated identically so their skew is preserved.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sdl_in,
  output logic sdl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_ff, sdl_ff;
  logic scl, scl_q, sdl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= '1;
      sdl_ff <= '1;
      scl_q  <= 1'b1;
      sdl_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_in};
      sdl_ff <= {sdl_ff[SYNC_STAGES-2:0], sdl_in};
      scl_q  <= scl;
      sdl_q  <= sdl;
    end
  end

  assign scl = scl_ff[SYNC_STAGES-1];
  assign sdl = sdl_ff[SYNC_STAGES-1];

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  // SCL must be high on both sides of the SDA edge to count as a bus condition
  assign start    = scl & scl_q & sdl_q & ~sdl;
  assign stop     = scl & scl_q & ~sdl_q & sdl;

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C slave exposing MEM_DEPTH byte registers behind an auto-incrementing pointer.
// Write: addr+W, pointer, data...; read: addr+R streams mem[ptr++] until NACK.
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         MEM_DEPTH   = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  input  logic             sdl_in,
  output logic             sdl_oe,
  output logic             busy,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data
);

  logic sdl, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl),
    .sdl_in   (sdl_in),
    .sdl      (sdl),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e       state, state_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             rw, rw_nxt;
  logic             oe_nxt, busy_nxt, mem_we;
  logic [7:0]       mem [MEM_DEPTH];
  logic [7:0]       rd_byte;

  assign rd_byte = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= RW_WRITE;
      sdl_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ptr     <= ptr_nxt;
      rw      <= rw_nxt;
      sdl_oe  <= oe_nxt;
      busy    <= busy_nxt;
      wr_stb  <= mem_we;
      if (mem_we) begin
        wr_addr <= ptr;
        wr_data <= shreg;
      end
    end
  end

  // Register file survives reset, so it has no reset branch
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= shreg;
  end

  // START beats STOP beats SCL edges; SDA is sampled on rises, SDL_OE moves only on falls.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ptr_nxt     = ptr;
    rw_nxt      = rw;
    oe_nxt      = sdl_oe;
    busy_nxt    = busy;
    mem_we      = 1'b0;
    if (start) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = '0;
      shreg_nxt   = '0;
      oe_nxt      = 1'b0;
    end else if (stop) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
      busy_nxt    = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (bit_cnt != BITS_PER_BYTE) begin
            shreg_nxt   = {shreg[6:0], sdl};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
        ST_RD_DATA: begin
          if (bit_cnt != BITS_PER_BYTE) bit_cnt_nxt = bit_cnt + 4'd1;
        end
        ST_RD_ACK: begin
          if (sdl == I2C_NACK) begin
            state_nxt = ST_WAIT_STOP;
            busy_nxt  = 1'b0;
          end else begin
            ptr_nxt     = ptr + PTR_W'(1);
            bit_cnt_nxt = 4'd1;  // marks "master ACKed", next byte loads on the fall
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ST_ADDR: begin
          if (bit_cnt == BITS_PER_BYTE) begin
            bit_cnt_nxt = '0;
            if (shreg[7:1] == SLAVE_ADDR) begin
              state_nxt = ST_ADDR_ACK;
              rw_nxt    = shreg[0];
              oe_nxt    = 1'b1;
              busy_nxt  = 1'b1;
            end else begin
              state_nxt = ST_WAIT_STOP;
              busy_nxt  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          bit_cnt_nxt = '0;
          if (rw == RW_READ) begin
            state_nxt = ST_RD_DATA;
            shreg_nxt = rd_byte;
            oe_nxt    = ~rd_byte[7];
          end else begin
            state_nxt = ST_PTR;
            oe_nxt    = 1'b0;
          end
        end
        ST_PTR: begin
          if (bit_cnt == BITS_PER_BYTE) begin
            state_nxt   = ST_PTR_ACK;
            ptr_nxt     = shreg[PTR_W-1:0];
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b1;
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          state_nxt   = ST_WR_DATA;
          bit_cnt_nxt = '0;
          oe_nxt      = 1'b0;
        end
        ST_WR_DATA: begin
          if (bit_cnt == BITS_PER_BYTE) begin
            state_nxt   = ST_WR_ACK;
            mem_we      = 1'b1;
            ptr_nxt     = ptr + PTR_W'(1);
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (bit_cnt == BITS_PER_BYTE) begin
            state_nxt   = ST_RD_ACK;
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b0;
          end else if (bit_cnt != 4'd0) begin
            shreg_nxt = {shreg[6:0], 1'b0};
            oe_nxt    = ~shreg[6];
          end
        end
        ST_RD_ACK: begin
          if (bit_cnt == 4'd1) begin
            state_nxt   = ST_RD_DATA;
            bit_cnt_nxt = '0;
            shreg_nxt   = rd_byte;
            oe_nxt      = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master, write table, read-back scoreboard, reset/abort cases.
module tb_i2c_slave_mem;
  import i2c_pkg::*;

  localparam int Q     = 5;
  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic          clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  logic          sdl_in, sdl_oe, busy, wr_stb;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;

  assign sdl_in = ~(m_low | sdl_oe);

  i2c_slave_mem #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sdl_in(sdl_in), .sdl_oe(sdl_oe),
    .busy(busy), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [7:0] ab; logic [7:0] ptr; logic [7:0] d0; logic [7:0] d1; logic exp_ack; } vec_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] model [DEPTH];
  int         checks = 0, errors = 0;
  logic       oe_seen = 1'b0, busy_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every WR_STB must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n) begin
      if (sdl_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (wr_stb) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_stb_unexpected: got addr %0d data %0h expected no write", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            errors++;
            $display("FAIL wr_stb: got addr %0d data %0h expected addr %0d data %0h",
                     wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic qwait(); repeat (Q) @(negedge clk); endtask

  task automatic bus_start();
    m_low = 1'b0; qwait(); scl = 1'b1; qwait(); m_low = 1'b1; qwait(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    qwait(); m_low = 1'b1; qwait(); scl = 1'b1; qwait(); m_low = 1'b0; qwait();
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    qwait(); m_low = ~b; qwait(); scl = 1'b1; qwait(); s = sdl_in; qwait(); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin bit_xfer(1'b1, s); d[i] = s; end
    bit_xfer(~mack, s);
  endtask

  // Random read of n bytes starting at p; model values are queued before the bytes arrive
  task automatic read_txn(input string name, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    bus_start(); send_byte(8'hA0, ack); chk({name, "_addr_ack"}, ack, 1'b1);
    send_byte(p, ack); chk({name, "_ptr_ack"}, ack, 1'b1);
    bus_start(); send_byte(8'hA1, ack); chk({name, "_raddr_ack"}, ack, 1'b1);
    for (int i = 0; i < n; i++) rd_q.push_back(model[(p + i) % DEPTH]);
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, d);
      chk({name, "_rd_byte"}, d, rd_q.pop_front());
    end
    qwait();
    chk({name, "_oe_after_nack"}, sdl_oe, 1'b0);
    chk({name, "_busy_after_nack"}, busy, 1'b0);
    bus_stop();
  endtask

  vec_t vt[4];

  initial begin
    logic ack;
    logic s;
    vt[0] = '{8'hA0, 8'h03, 8'h11, 8'h22, 1'b1};
    vt[1] = '{8'hA0, 8'h0F, 8'hAA, 8'hBB, 1'b1};
    vt[2] = '{8'hA2, 8'h55, 8'h66, 8'h77, 1'b0};
    vt[3] = '{8'hA0, 8'hF6, 8'h5A, 8'hC3, 1'b1};

    repeat (4) @(negedge clk);
    chk("rst_sdl_oe", sdl_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_wr_addr", wr_addr, 4'd0);
    chk("rst_wr_data", wr_data, 8'd0);
    rst_n = 1'b1;
    qwait();

    for (int i = 0; i < 4; i++) begin
      logic [PW-1:0] p;
      p = vt[i].ptr[PW-1:0];
      oe_seen = 1'b0; busy_seen = 1'b0;
      bus_start();
      send_byte(vt[i].ab, ack); chk("vec_addr_ack", ack, vt[i].exp_ack);
      if (vt[i].exp_ack) chk("vec_busy_active", busy, 1'b1);
      send_byte(vt[i].ptr, ack); chk("vec_ptr_ack", ack, vt[i].exp_ack);
      if (vt[i].exp_ack) begin wr_q.push_back('{p, vt[i].d0}); model[p] = vt[i].d0; end
      send_byte(vt[i].d0, ack); chk("vec_d0_ack", ack, vt[i].exp_ack);
      p = p + 1'b1;
      if (vt[i].exp_ack) begin wr_q.push_back('{p, vt[i].d1}); model[p] = vt[i].d1; end
      send_byte(vt[i].d1, ack); chk("vec_d1_ack", ack, vt[i].exp_ack);
      bus_stop();
      chk("vec_busy_after_stop", busy, 1'b0);
      if (!vt[i].exp_ack) begin
        chk("mismatch_oe_never", oe_seen, 1'b0);
        chk("mismatch_busy_never", busy_seen, 1'b0);
      end
    end
    chk("wr_q_drained_writes", wr_q.size(), 0);

    read_txn("rd_basic", 8'h03, 2);
    read_txn("rd_wrap", 8'h0F, 2);
    read_txn("rd_upper", 8'h06, 3);

    // Reset in the middle of data bit 4 of a write to index 3
    bus_start(); send_byte(8'hA0, ack); send_byte(8'h03, ack);
    chk("rstmid_busy_before", busy, 1'b1);
    for (int i = 0; i < 3; i++) bit_xfer(1'b0, s);
    qwait(); m_low = 1'b1; qwait(); scl = 1'b1; @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_sdl_oe", sdl_oe, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_wr_stb", wr_stb, 1'b0);
    m_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qwait();
    read_txn("rstmid_mem", 8'h03, 1);

    // STOP after 5 data bits to index 4: byte must be dropped
    bus_start(); send_byte(8'hA0, ack); send_byte(8'h04, ack);
    for (int i = 0; i < 5; i++) bit_xfer(1'b1, s);
    bus_stop();
    chk("abort_busy", busy, 1'b0);
    read_txn("abort_mem", 8'h04, 1);

    repeat (4) @(negedge clk);
    chk("wr_q_drained_end", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
